// File: rtl/axil_master_pkg.sv
// Shared types for the AXI-Lite single-beat initiator: FSM states, response codes, latched command.
package axil_master_pkg;

   localparam int AXIL_ADDR_W = 32;
   localparam int AXIL_DATA_W = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE,
      WR_REQ,
      WR_RESP,
      RD_REQ,
      RD_DATA,
      RESP
   } state_t;

   typedef struct packed {
      logic                     write;
      logic [AXIL_ADDR_W-1:0]   addr;
      logic [AXIL_DATA_W-1:0]   wdata;
      logic [AXIL_DATA_W/8-1:0] wstrb;
   } cmd_t;

endpackage

// File: rtl/axil_timeout_ctr.sv
// Saturating transaction-age counter; expired is high while the count sits at LIMIT.
// LIMIT of 0 disables expiry entirely.
module axil_timeout_ctr #(
   parameter int LIMIT = 1023
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

   logic [CW-1:0] count;

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && (count != CW'(LIMIT))) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (LIMIT != 0) && (count == CW'(LIMIT));

endmodule

// File: rtl/ocl_axil_master.sv
// AXI4-Lite single-beat initiator: one command at a time, zero-wait latency accept->rsp_valid of 3 cycles.
// Command port stalls (cmd_ready low) until the previous response is consumed; hung slaves are aborted by timeout.
module ocl_axil_master
   import axil_master_pkg::*;
#(
   parameter int ADDR_W         = AXIL_ADDR_W,
   parameter int DATA_W         = AXIL_DATA_W,
   parameter int TIMEOUT_CYCLES = 1023
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_write,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_wstrb,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic [1:0]          rsp_resp,
   output logic                rsp_timeout,
   output logic                m_axi_awvalid,
   input  logic                m_axi_awready,
   output logic [ADDR_W-1:0]   m_axi_awaddr,
   output logic                m_axi_wvalid,
   input  logic                m_axi_wready,
   output logic [DATA_W-1:0]   m_axi_wdata,
   output logic [DATA_W/8-1:0] m_axi_wstrb,
   input  logic                m_axi_bvalid,
   output logic                m_axi_bready,
   input  logic [1:0]          m_axi_bresp,
   output logic                m_axi_arvalid,
   input  logic                m_axi_arready,
   output logic [ADDR_W-1:0]   m_axi_araddr,
   input  logic                m_axi_rvalid,
   output logic                m_axi_rready,
   input  logic [DATA_W-1:0]   m_axi_rdata,
   input  logic [1:0]          m_axi_rresp
);

   localparam int STRB_W = DATA_W / 8;

   state_t            state, state_nxt;
   cmd_t              cmd_q;
   logic              aw_done, w_done;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        resp_q;
   logic              timeout_q;
   logic              accept, abort, expired, busy;
   logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, aw_fin, w_fin;

   assign accept = cmd_valid && cmd_ready;
   assign aw_hs  = m_axi_awvalid && m_axi_awready;
   assign w_hs   = m_axi_wvalid && m_axi_wready;
   assign b_hs   = m_axi_bvalid && m_axi_bready;
   assign ar_hs  = m_axi_arvalid && m_axi_arready;
   assign r_hs   = m_axi_rvalid && m_axi_rready;
   assign aw_fin = aw_done || aw_hs;
   assign w_fin  = w_done || w_hs;
   assign busy   = (state == WR_REQ) || (state == WR_RESP) || (state == RD_REQ) || (state == RD_DATA);

   axil_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clock   (clock),
      .reset   (reset),
      .clear   (accept),
      .enable  (busy),
      .expired (expired)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A handshake landing in the expiry cycle completes normally; abort only if it is still pending.
   always_comb begin
      state_nxt     = state;
      abort         = 1'b0;
      cmd_ready     = 1'b0;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_bready  = 1'b0;
      m_axi_arvalid = 1'b0;
      m_axi_rready  = 1'b0;
      rsp_valid     = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            if (cmd_valid) state_nxt = cmd_write ? WR_REQ : RD_REQ;
         end
         WR_REQ: begin
            m_axi_awvalid = !aw_done;
            m_axi_wvalid  = !w_done;
            if (aw_fin && w_fin) state_nxt = WR_RESP;
            else if (expired)    abort = 1'b1;
         end
         WR_RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid) state_nxt = RESP;
            else if (expired) abort = 1'b1;
         end
         RD_REQ: begin
            m_axi_arvalid = 1'b1;
            if (m_axi_arready) state_nxt = RD_DATA;
            else if (expired)  abort = 1'b1;
         end
         RD_DATA: begin
            m_axi_rready = 1'b1;
            if (m_axi_rvalid) state_nxt = RESP;
            else if (expired) abort = 1'b1;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = RESP;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cmd_q     <= '0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         rdata_q   <= '0;
         resp_q    <= RESP_OKAY;
         timeout_q <= 1'b0;
      end else begin
         if (accept) begin
            cmd_q   <= '{write: cmd_write,
                         addr:  AXIL_ADDR_W'(cmd_addr),
                         wdata: AXIL_DATA_W'(cmd_wdata),
                         wstrb: (AXIL_DATA_W/8)'(cmd_wstrb)};
            aw_done <= 1'b0;
            w_done  <= 1'b0;
         end else if (state == WR_REQ) begin
            aw_done <= aw_fin;
            w_done  <= w_fin;
         end
         if (b_hs || r_hs) begin
            rdata_q   <= cmd_q.write ? '0 : m_axi_rdata;
            resp_q    <= cmd_q.write ? m_axi_bresp : m_axi_rresp;
            timeout_q <= 1'b0;
         end else if (abort) begin
            rdata_q   <= '0;
            resp_q    <= RESP_SLVERR;
            timeout_q <= 1'b1;
         end
      end
   end

   assign m_axi_awaddr = ADDR_W'(cmd_q.addr);
   assign m_axi_araddr = ADDR_W'(cmd_q.addr);
   assign m_axi_wdata  = DATA_W'(cmd_q.wdata);
   assign m_axi_wstrb  = STRB_W'(cmd_q.wstrb);
   assign rsp_rdata    = rdata_q;
   assign rsp_resp     = resp_q;
   assign rsp_timeout  = timeout_q;

endmodule
